top_spi_master: RTL and testbench

TOP_SPI_MASTER -- requirements
Module: top_spi_master

---
 rtl/spi_pkg.sv | 13 +
 rtl/miso_tri_bus.sv | 18 +
 rtl/spi_master_core.sv | 117 +++++++++++
 rtl/top_spi_master.sv | 57 +++++
 tb/tb_top_spi_master.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and default word/slave counts.
// Used by spi_master_core, miso_tri_bus and top_spi_master.
package spi_pkg;
    localparam int SPI_NBITS  = 8;
    localparam int SPI_NSLAVE = 4;

    typedef enum logic [1:0] {
        IDLE,
        CPHA_DELAY,
        P0,
        P1
    } state_t;
endpackage

// File: rtl/miso_tri_bus.sv
// Shares one miso line among slaves: the slave whose active-low select is low drives it, else high-Z.
// Purely combinational, zero latency, no flow control.
module miso_tri_bus
    import spi_pkg::*;
#(
    parameter int NSLAVE = SPI_NSLAVE
) (
    input  logic [NSLAVE-1:0] miso_in,
    input  logic [NSLAVE-1:0] cs_n,
    output logic              miso
);
    logic any_sel;
    logic sel_bit;

    assign any_sel = ~&cs_n;
    assign sel_bit = |(miso_in & ~cs_n);
    assign miso    = any_sel ? sel_bit : 1'bz;
endmodule

// File: rtl/spi_master_core.sv
// SPI serial engine: phase timing, mosi shift-out and miso shift-in; SPI_LSB_FIRST_EN enables lsb_first.
// done pulses 2*NBITS*(dvsr+1) clk edges after the accepting edge (+dvsr+1 with cpha); start ignored while busy.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int NBITS = SPI_NBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] tx_data,
    input  logic [15:0]      dvsr,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsb_first,
    input  logic             miso,
    output logic [NBITS-1:0] rx_data,
    output logic             ready,
    output logic             spi_done_tick,
    output logic             sclk,
    output logic             mosi
);
    localparam int BW = $clog2(NBITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

    state_t           state;
    logic [15:0]      cnt;
    logic [15:0]      dvsr_r;
    logic [BW-1:0]    bit_cnt;
    logic [NBITS-1:0] tx_sh;
    logic             cpol_r;
    logic             cpha_r;
    logic             lsb_r;
    logic             lsb_sel;
    logic             phase_end;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_sel = lsb_first;
`else
    logic unused_lsb;
    assign unused_lsb = lsb_first;
    assign lsb_sel    = 1'b0;
`endif

    assign phase_end = (cnt == dvsr_r);
    assign mosi      = lsb_r ? tx_sh[0] : tx_sh[NBITS-1];
    // Idle level tracks the live cpol so the line is already parked before start.
    assign sclk      = (state == IDLE) ? cpol : ((state == P1) ^ cpha_r ^ cpol_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            dvsr_r        <= '0;
            bit_cnt       <= '0;
            tx_sh         <= '0;
            rx_data       <= '0;
            cpol_r        <= 1'b0;
            cpha_r        <= 1'b0;
            lsb_r         <= 1'b0;
            ready         <= 1'b1;
            spi_done_tick <= 1'b0;
        end else begin
            spi_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh   <= tx_data;
                        dvsr_r  <= dvsr;
                        cpol_r  <= cpol;
                        cpha_r  <= cpha;
                        lsb_r   <= lsb_sel;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        ready   <= 1'b0;
                        state   <= cpha ? CPHA_DELAY : P0;
                    end
                end
                CPHA_DELAY: begin
                    if (phase_end) begin
                        cnt   <= '0;
                        state <= P0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                P0: begin
                    if (phase_end) begin
                        cnt     <= '0;
                        state   <= P1;
                        rx_data <= lsb_r ? ((rx_data >> 1) | (NBITS'(miso) << (NBITS - 1)))
                                         : ((rx_data << 1) | NBITS'(miso));
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                P1: begin
                    if (phase_end) begin
                        cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state         <= IDLE;
                            ready         <= 1'b1;
                            spi_done_tick <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sh   <= lsb_r ? (tx_sh >> 1) : (tx_sh << 1);
                            state   <= P0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/top_spi_master.sv
// SPI master with active-low one-hot slave select; bit order option gated by SPI_LSB_FIRST_EN.
// done 2*NBITS*(dvsr+1) edges after accept (+dvsr+1 with cpha); start ignored while ready=0.
module top_spi_master
    import spi_pkg::*;
#(
    parameter int NBITS  = SPI_NBITS,
    parameter int NSLAVE = SPI_NSLAVE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NBITS-1:0]          tx_data,
    input  logic [15:0]               dvsr,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic                      lsb_first,
    input  logic [$clog2(NSLAVE)-1:0] cs_num,
    input  logic                      miso,
    output logic [NBITS-1:0]          rx_data,
    output logic                      ready,
    output logic                      spi_done_tick,
    output logic                      sclk,
    output logic                      mosi,
    output logic [NSLAVE-1:0]         cs_decode
);
    logic [$clog2(NSLAVE)-1:0] cs_r;

    spi_master_core #(
        .NBITS(NBITS)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tx_data      (tx_data),
        .dvsr         (dvsr),
        .cpol         (cpol),
        .cpha         (cpha),
        .lsb_first    (lsb_first),
        .miso         (miso),
        .rx_data      (rx_data),
        .ready        (ready),
        .spi_done_tick(spi_done_tick),
        .sclk         (sclk),
        .mosi         (mosi)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_r <= '0;
        end else if (start && ready) begin
            cs_r <= cs_num;
        end
    end

    // ready is low exactly while a transfer owns the bus, so it gates the select.
    assign cs_decode = ready ? '1 : ~(NSLAVE'(1) << cs_r);
endmodule

// File: tb/tb_top_spi_master.sv
// Randomized bench for top_spi_master against a protocol-level SPI slave model, plus miso_tri_bus checks.
module tb_top_spi_master;
    localparam int NB = 8;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NB-1:0] tx_data;
    logic [15:0]   dvsr;
    logic          cpol;
    logic          cpha;
    logic          lsb_first;
    logic [1:0]    cs_num;
    logic          miso;
    logic [NB-1:0] rx_data;
    logic          ready;
    logic          spi_done_tick;
    logic          sclk;
    logic          mosi;
    logic [NS-1:0] cs_decode;

    logic [NS-1:0] tb_miso_in;
    logic [NS-1:0] tb_cs_n;
    wire           tb_miso;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    top_spi_master #(.NBITS(NB), .NSLAVE(NS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tx_data      (tx_data),
        .dvsr         (dvsr),
        .cpol         (cpol),
        .cpha         (cpha),
        .lsb_first    (lsb_first),
        .cs_num       (cs_num),
        .miso         (miso),
        .rx_data      (rx_data),
        .ready        (ready),
        .spi_done_tick(spi_done_tick),
        .sclk         (sclk),
        .mosi         (mosi),
        .cs_decode    (cs_decode)
    );

    miso_tri_bus #(.NSLAVE(NS)) u_bus (
        .miso_in(tb_miso_in),
        .cs_n   (tb_cs_n),
        .miso   (tb_miso)
    );

    // SPI slave: samples mosi on the leading edge for cpha=0 (trailing for cpha=1)
    // and moves to its next miso bit on the opposite edge.
    logic          xfer_on = 1'b0;
    logic          m_cpol, m_cpha, m_lsb, s_first;
    logic [NB-1:0] s_tx, s_rx;

    always @(sclk) begin
        if (xfer_on) begin
            if ((sclk != m_cpol) ^ m_cpha)
                s_rx = m_lsb ? {mosi, s_rx[NB-1:1]} : {s_rx[NB-2:0], mosi};
            else if (m_cpha && s_first)
                s_first = 1'b0;
            else
                s_tx = m_lsb ? (s_tx >> 1) : (s_tx << 1);
        end
    end

    assign miso = m_lsb ? s_tx[0] : s_tx[NB-1];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_xfer(input logic [NB-1:0] tx, input logic [NB-1:0] sw, input logic [15:0] dv,
                           input logic pol, input logic pha, input logic lsb, input logic [1:0] cs);
        int            lat, exp_lat, ndone, cs_bad;
        logic          eff_lsb;
        logic [NS-1:0] cs_exp;
        eff_lsb = lsb;
`ifndef SPI_LSB_FIRST_EN
        eff_lsb = 1'b0;
`endif
        cs_exp = ~(NS'(1) << cs);
        @(negedge clk);
        tx_data = tx; dvsr = dv; cpol = pol; cpha = pha; lsb_first = lsb; cs_num = cs;
        @(negedge clk);
        chk_eq("ready_before_start", 32'(ready), 1);
        m_cpol = pol; m_cpha = pha; m_lsb = eff_lsb;
        s_tx = sw; s_rx = '0; s_first = 1'b1; xfer_on = 1'b1;
        exp_lat = (pha ? (2 * NB + 1) : (2 * NB)) * (int'(dv) + 1);
        lat = -1; ndone = 0; cs_bad = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (cs_decode !== cs_exp || ready !== 1'b0) cs_bad++;
        // Captured settings must not follow the live inputs (cpol stays, it sets idle sclk).
        tx_data = NB'($urandom); dvsr = 16'($urandom_range(0, 7));
        cpha = ~pha; lsb_first = ~lsb; cs_num = cs ^ 2'b01;
        for (int cyc = 1; cyc <= exp_lat + 4; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == 3);
            if (spi_done_tick) begin
                ndone++;
                if (lat < 0) lat = cyc;
                xfer_on = 1'b0;
            end
            if (lat < 0 && cs_decode !== cs_exp) cs_bad++;
            if (lat == cyc && (cs_decode !== '1 || ready !== 1'b1)) cs_bad++;
        end
        start = 1'b0;
        xfer_on = 1'b0;
        chk_eq("latency", lat, exp_lat);
        chk_eq("done_pulses", ndone, 1);
        chk_eq("cs_window_errors", cs_bad, 0);
        chk_eq("rx_data", 32'(rx_data), 32'(sw));
        chk_eq("slave_rx", 32'(s_rx), 32'(tx));
        chk_eq("sclk_idle", 32'(sclk), 32'(pol));
    endtask

    task automatic reset_mid();
        @(negedge clk);
        tx_data = 8'hC3; dvsr = 16'd2; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; cs_num = 2'd1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_eq("rst_mid_cs", 32'(cs_decode), 32'hF);
        chk_eq("rst_mid_ready", 32'(ready), 1);
        chk_eq("rst_mid_done", 32'(spi_done_tick), 0);
        chk_eq("rst_mid_rx", 32'(rx_data), 0);
        chk_eq("rst_mid_mosi", 32'(mosi), 0);
        chk_eq("rst_mid_sclk", 32'(sclk), 1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic zexp;
        reset = 1'b1; start = 1'b0; tx_data = '0; dvsr = '0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; cs_num = '0;
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; s_tx = '0; s_rx = '0; s_first = 1'b0;
        tb_cs_n = '1; tb_miso_in = '0;
        #12;
        chk_eq("rst_ready", 32'(ready), 1);
        chk_eq("rst_done", 32'(spi_done_tick), 0);
        chk_eq("rst_cs", 32'(cs_decode), 32'hF);
        chk_eq("rst_rx", 32'(rx_data), 0);
        chk_eq("rst_mosi", 32'(mosi), 0);
        chk_eq("rst_sclk", 32'(sclk), 0);
        cpol = 1'b1;
        #1 chk_eq("idle_sclk_live_cpol", 32'(sclk), 1);
        @(negedge clk);
        reset = 1'b0;

        do_xfer(8'hA5, 8'h7B, 16'd4, 1'b0, 1'b0, 1'b0, 2'd0);
        do_xfer(8'h3C, 8'hE9, 16'd2, 1'b0, 1'b1, 1'b0, 2'd1);
        do_xfer(8'hDB, 8'hF9, 16'd1, 1'b1, 1'b0, 1'b1, 2'd2);
        do_xfer(8'h48, 8'h21, 16'd0, 1'b1, 1'b1, 1'b1, 2'd3);
        reset_mid();
        do_xfer(8'h96, 8'h5A, 16'd0, 1'b0, 1'b0, 1'b0, 2'd2);
        for (int i = 0; i < 10; i++)
            do_xfer(NB'($urandom), NB'($urandom), 16'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));

        tb_cs_n = 4'b1011; tb_miso_in = 4'b0100;
        #1 chk_eq("tri_sel_high", 32'(tb_miso), 1);
        tb_miso_in = 4'b1011;
        #1 chk_eq("tri_sel_low", 32'(tb_miso), 0);
        tb_cs_n = 4'b1111; tb_miso_in = 4'b1111;
        zexp = 1'bz;
        #1 chk_eq("tri_off", 32'(tb_miso), 32'(zexp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
